rob_ctrl: RTL

- Head/tail pointer controller for the reorder buffer register file.
- Allocates ROB tags at decode and tracks per-entry valid and complete bits.
- Retires the head entry in order through a commit handshake.
- Drives the ROB register file's decode write address and enable, commit read address, and per-entry synchronous clears (retire, flush, reset).

---
 rtl/rob_pkg.sv | 7 +
 rtl/rob_ptr.sv | 16 +
 rtl/rob_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared sizes and types for the reorder buffer controller
package rob_pkg;
    localparam int ROB_SIZE   = 8;
    localparam int ROB_ADDR_W = $clog2(ROB_SIZE);
    typedef logic [ROB_ADDR_W-1:0] rob_tag_t;
    typedef logic [ROB_ADDR_W:0]   rob_count_t;
endpackage

// File: rtl/rob_ptr.sv
// rob_ptr: wrapping pointer register with increment enable and synchronous clear
module rob_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    // Power-of-two depth, so natural overflow gives the wrap
    always_ff @(posedge clk) begin
        if (!rst_n || clr) ptr <= '0;
        else if (inc)      ptr <= ptr + W'(1);
    end
endmodule

// File: rtl/rob_ctrl.sv
// rob_ctrl: head/tail controller for the reorder buffer register file
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int ROBsize  = ROB_SIZE,
    parameter int addrSize = $clog2(ROBsize)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    output logic [addrSize-1:0] alloc_tag_o,
    output logic                decodeWriteEn_o,
    input  logic                complete_valid_i,
    input  logic [addrSize-1:0] complete_tag_i,
    output logic                commit_valid_o,
    input  logic                commit_ready_i,
    output logic [addrSize-1:0] commitReadAddr_o,
    input  logic                flush_i,
    output logic [ROBsize-1:0]  resets_o,
    output logic [addrSize:0]   count_o,
    output logic                empty_o
);
    logic [ROBsize-1:0] valid, done;
    logic               pop;

    rob_ptr #(.W(addrSize)) u_head (
        .clk(clk_i), .rst_n(reset_n_i), .clr(flush_i), .inc(pop), .ptr(commitReadAddr_o)
    );
    rob_ptr #(.W(addrSize)) u_tail (
        .clk(clk_i), .rst_n(reset_n_i), .clr(flush_i), .inc(decodeWriteEn_o), .ptr(alloc_tag_o)
    );

    // Handshakes and register-file controls; no room is created by a same-cycle pop
    always_comb begin
        alloc_ready_o   = count_o != (addrSize+1)'(ROBsize);
        decodeWriteEn_o = alloc_valid_i & alloc_ready_o & ~flush_i;
        commit_valid_o  = valid[commitReadAddr_o] & done[commitReadAddr_o];
        pop             = commit_valid_o & commit_ready_i & ~flush_i;
        empty_o         = count_o == '0;
        resets_o        = (!reset_n_i || flush_i) ? '1 :
                          pop ? (ROBsize'(1) << commitReadAddr_o) : '0;
    end

    // Entry state: completion first, so a pop of the same entry or a fresh allocation overrides it
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_i) begin
            valid   <= '0;
            done    <= '0;
            count_o <= '0;
        end else begin
            if (complete_valid_i && valid[complete_tag_i]) done[complete_tag_i] <= 1'b1;
            if (pop) begin
                valid[commitReadAddr_o] <= 1'b0;
                done[commitReadAddr_o]  <= 1'b0;
            end
            if (decodeWriteEn_o) begin
                valid[alloc_tag_o] <= 1'b1;
                done[alloc_tag_o]  <= 1'b0;
            end
            count_o <= count_o + (addrSize+1)'(decodeWriteEn_o) - (addrSize+1)'(pop);
        end
    end
endmodule
